// File: rtl/div_sequencer.sv
// Restoring 32/32 unsigned divider sequenced by an IDLE/ITER/DONE FSM on the falling clock edge.
// Fixed latency: accept, 32 iterations, one DONE cycle; divide-by-zero short-circuits to DONE.
module div_sequencer (
  input  logic        clk,
  input  logic        r,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic [5:0]  iter_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ITER = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] qsr_q, qsr_d;
  logic [32:0] prem_q, prem_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic        dbz_q, dbz_d;

  logic [32:0] shifted;
  logic [33:0] trial;
  logic        trial_neg;
  logic [32:0] step_prem;
  logic [31:0] step_qsr;

  // The partial remainder never reaches the divisor, so the shifted value fits in 33 bits.
  assign shifted   = {prem_q[31:0], qsr_q[31]};
  assign trial     = {prem_q, qsr_q[31]} - {2'b00, dvs_q};
  assign trial_neg = trial[33];
  assign step_prem = trial_neg ? shifted : trial[32:0];
  assign step_qsr  = {qsr_q[30:0], ~trial_neg};

  always_comb begin
    state_d = state_q;
    dvs_d   = dvs_q;
    qsr_d   = qsr_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dvs_d  = divisor;
          qsr_d  = dividend;
          prem_d = '0;
          cnt_d  = '0;
          if (divisor == 32'd0) begin
            quo_d   = 32'hFFFF_FFFF;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = ITER;
          end
        end
      end
      ITER: begin
        prem_d = step_prem;
        qsr_d  = step_qsr;
        cnt_d  = cnt_q + 6'd1;
        // Results are published only on the final step, never mid-operation.
        if (cnt_q == 6'd31) begin
          quo_d   = step_qsr;
          rem_d   = step_prem[31:0];
          dbz_d   = 1'b0;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk or posedge r) begin
    if (r) begin
      state_q <= IDLE;
      dvs_q   <= '0;
      qsr_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvs_q   <= dvs_d;
      qsr_q   <= qsr_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
    end
  end

  assign busy        = (state_q == ITER);
  assign done        = (state_q == DONE);
  assign div_by_zero = dbz_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign iter_count  = cnt_q;

endmodule

// File: doc/div_sequencer.md
DIV_SEQUENCER -- requirements
Module: div_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the ports are named clk and r.
REQ-002 clk  input  1  sole clock; all state updates on the falling edge.
REQ-003 r  input  1  asynchronous active-high reset.
REQ-004 start  input  1  request a division; sampled only in IDLE.
REQ-005 dividend  input  32  unsigned dividend; captured on the accepting edge.
REQ-006 divisor  input  32  unsigned divisor; captured on the accepting edge.
REQ-007 busy  output  1  high while in ITER.
REQ-008 done  output  1  single-cycle completion pulse, high in DONE.
REQ-009 div_by_zero  output  1  set when the completed operation had divisor 0.
REQ-010 quotient  output  32  result quotient.
REQ-011 remainder  output  32  result remainder.
REQ-012 iter_count  output  6  iterations completed in the current operation, 0..32.

Function
REQ-013 The FSM SHALL have three states: IDLE, ITER and DONE, each registered on the falling edge of clk.
REQ-014 IDLE with start=1 at an edge SHALL capture dividend and divisor into internal registers, clear the partial remainder (33 bits) and iter_count, and go to ITER; divisor=0 instead goes to DONE.
REQ-015 IDLE with start=0 SHALL stay in IDLE with no state change.
REQ-016 Each ITER edge SHALL perform one restoring step: shift {partial remainder, quotient shift register} left by 1; trial = partial remainder - {1'b0, divisor} (33 bits); if trial is non-negative, load it into the partial remainder and set the quotient LSB to 1, else keep the partial remainder and set the LSB to 0; then increment iter_count.
REQ-017 The step on which iter_count reaches 32 SHALL load quotient and remainder (low 32 bits) and go to DONE.
REQ-018 Latency SHALL be fixed: accept edge E0, iterations on edges E1..E32, done=1 from E32 until E33, back in IDLE after E33.
REQ-019 For divisor=0, the accepting edge SHALL set quotient=32'hFFFFFFFF, remainder=dividend and div_by_zero=1, and go to DONE; done is high for the following cycle.
REQ-020 DONE SHALL last exactly one cycle and then go to IDLE unconditionally; start is ignored in DONE.
REQ-021 start asserted in ITER or DONE SHALL be ignored, and no captured operand changes.
REQ-022 Changes on dividend or divisor after the accepting edge SHALL NOT affect the operation in progress.
REQ-023 quotient, remainder and div_by_zero SHALL change only on result load (REQ-017, REQ-019) and SHALL hold until the next result load or reset; intermediate values are never visible on them.
REQ-024 div_by_zero SHALL be cleared on the result load of any operation with a non-zero divisor.
REQ-025 busy SHALL be 1 exactly when the state is ITER; done SHALL be 1 exactly when the state is DONE; the two are never high together.
REQ-026 iter_count SHALL hold 32 in DONE and reset to 0 on the next accepting edge.
REQ-027 Back-to-back operations SHALL be possible: start held high through DONE is accepted on the first edge in IDLE.

Reset
REQ-028 r=1 SHALL immediately, without waiting for clk, force state IDLE and clear busy, done, div_by_zero, quotient, remainder, iter_count and all internal registers to 0.
REQ-029 Reset during ITER SHALL abandon the operation; no partial result is ever loaded to the outputs.
REQ-030 After r is deasserted, the first falling edge with start=1 SHALL start a new operation normally.

Verification
REQ-031 dividend=100, divisor=7, start pulsed one cycle -> busy for 32 cycles, done pulse after E32, quotient=14, remainder=2, div_by_zero=0.
REQ-032 dividend=32'hFFFFFFFF, divisor=1 -> quotient=32'hFFFFFFFF, remainder=0; then dividend=32'hFFFFFFFF, divisor=32'hFFFFFFFF -> quotient=1, remainder=0.
REQ-033 dividend=5, divisor=0 -> done one cycle after accept with busy never high, quotient=32'hFFFFFFFF, remainder=5, div_by_zero=1; a following 9/4 gives quotient=2, remainder=1, div_by_zero=0.
REQ-034 dividend=3, divisor=10 -> quotient=0, remainder=3; start re-pulsed with 50/5 at iteration 10 is ignored and the 3/10 result stands.
REQ-035 r pulsed at iter_count=10 during 1000/3 -> all outputs 0 asynchronously, state IDLE; a new 1000/3 then gives quotient=333, remainder=1.
REQ-036 start held high continuously with 20/6 -> consecutive results quotient=3, remainder=2, with done pulses spaced 34 cycles apart.
